// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle MIPS control unit.
// The master side is the controller and the slave side is the datapath.
`timescale 1ns/1ps
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 6);
  logic [5:0]       opcode;
  logic             equal;
  logic             overflow;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src_jump;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] instr_num;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic             trap;

  modport master (
    input  opcode, equal, overflow,
    output ir_write, pc_write, pc_src_jump, mem_read, mem_write, reg_write,
           alu_src_b, alu_op, instr_num, state, halted, illegal, trap
  );

  modport slave (
    output opcode, equal, overflow,
    input  ir_write, pc_write, pc_src_jump, mem_read, mem_write, reg_write,
           alu_src_b, alu_op, instr_num, state, halted, illegal, trap
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB plus HALT and TRAP.
// Define OVERFLOW_TRAP_EN to divert overflowing R/addi results into TRAP.
`timescale 1ns/1ps
module mips_multicycle_ctrl #(
  parameter int CNT_W = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t           cur, nxt;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q, illegal_set;
  logic             ovf_trap;
  logic             ir_w, pc_w, jump, mrd, mwr, rwr;
  logic [1:0]       src_b, aop;

`ifdef OVERFLOW_TRAP_EN
  logic trap_q;
  assign ovf_trap = bus.overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            trap_q <= 1'b0;
    else if (nxt == TRAP)  trap_q <= 1'b1;
  end

  assign bus.trap = trap_q;
`else
  logic unused_overflow;
  assign unused_overflow = bus.overflow;
  assign ovf_trap        = 1'b0;
  assign bus.trap        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= FETCH;
      op_q      <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op_q <= bus.opcode;
      if (cur == FETCH)  cnt  <= cnt + CNT_W'(1);
      if (illegal_set)   illegal_q <= 1'b1;
    end
  end

  // DECODE has to look at the live opcode (op_q is only loaded at its end),
  // and beq's pc_write follows the live equal flag in EXEC.
  always_comb begin
    nxt         = cur;
    illegal_set = 1'b0;
    ir_w        = 1'b0;
    pc_w        = 1'b0;
    jump        = 1'b0;
    mrd         = 1'b0;
    mwr         = 1'b0;
    rwr         = 1'b0;
    src_b       = 2'd0;
    aop         = 2'd0;
    case (cur)
      FETCH: begin
        ir_w  = 1'b1;
        pc_w  = 1'b1;
        src_b = 2'd1;
        nxt   = DECODE;
      end
      DECODE: begin
        case (bus.opcode)
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: nxt = EXEC;
          OP_J: begin
            pc_w = 1'b1;
            jump = 1'b1;
            nxt  = FETCH;
          end
          OP_HALT: nxt = HALT;
          default: begin
            illegal_set = 1'b1;
            nxt         = FETCH;
          end
        endcase
      end
      EXEC: begin
        case (op_q)
          OP_LW, OP_SW: begin
            src_b = 2'd2;
            nxt   = MEM;
          end
          OP_ADDI: begin
            src_b = 2'd2;
            nxt   = ovf_trap ? TRAP : WB;
          end
          OP_R: begin
            aop = 2'd2;
            nxt = ovf_trap ? TRAP : WB;
          end
          OP_BEQ: begin
            aop  = 2'd1;
            pc_w = bus.equal;
            nxt  = FETCH;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        if (op_q == OP_LW) begin
          mrd = 1'b1;
          nxt = WB;
        end else begin
          mwr = (op_q == OP_SW);
          nxt = FETCH;
        end
      end
      WB: begin
        rwr = 1'b1;
        nxt = FETCH;
      end
      TRAP:    nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // Reset state is FETCH, so strobes are masked while rst_n is low.
  assign bus.ir_write    = rst_n & ir_w;
  assign bus.pc_write    = rst_n & pc_w;
  assign bus.pc_src_jump = rst_n & jump;
  assign bus.mem_read    = rst_n & mrd;
  assign bus.mem_write   = rst_n & mwr;
  assign bus.reg_write   = rst_n & rwr;
  assign bus.alu_src_b   = {2{rst_n}} & src_b;
  assign bus.alu_op      = {2{rst_n}} & aop;
  assign bus.instr_num   = cnt;
  assign bus.state       = cur;
  assign bus.halted      = (cur == HALT);
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle trace,
// a negedge monitor pops and compares one entry per clock.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 6;

  typedef struct packed {
    logic [2:0]       st;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src_jump;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] instr_num;
    logic             halted;
    logic             illegal;
    logic             trap;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  obs_t             sb[$];
  int               n_chk = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_ill = 1'b0;
  logic             m_trap = 1'b0;

  function automatic obs_t sample();
    obs_t s;
    s.st          = bus.state;
    s.ir_write    = bus.ir_write;
    s.pc_write    = bus.pc_write;
    s.pc_src_jump = bus.pc_src_jump;
    s.mem_read    = bus.mem_read;
    s.mem_write   = bus.mem_write;
    s.reg_write   = bus.reg_write;
    s.alu_src_b   = bus.alu_src_b;
    s.alu_op      = bus.alu_op;
    s.instr_num   = bus.instr_num;
    s.halted      = bus.halted;
    s.illegal     = bus.illegal;
    s.trap        = bus.trap;
    return s;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got state=%0d bits=%h, expected state=%0d bits=%h",
               name, $time, act.st, act, exp.st, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cycle", sample(), e);
    end
  end

  function automatic obs_t base(input logic [2:0] st, input logic [CNT_W-1:0] c);
    obs_t r;
    r           = '0;
    r.st        = st;
    r.instr_num = c;
    r.illegal   = m_ill;
    r.trap      = m_trap;
    return r;
  endfunction

  // Reference trace of one instruction, written from the per-opcode behaviour.
  task automatic issue(input logic [5:0] op, input logic eq, input logic ovf,
                       input int halt_cycles, output int n);
    obs_t r;
    bus.opcode   = op;
    bus.equal    = eq;
    bus.overflow = ovf;
    r = base(3'd0, m_cnt);
    r.ir_write = 1'b1; r.pc_write = 1'b1; r.alu_src_b = 2'd1;
    sb.push_back(r);
    m_cnt = m_cnt + 1'b1;
    r = base(3'd1, m_cnt);
    case (op)
      6'h02: begin
        r.pc_write = 1'b1; r.pc_src_jump = 1'b1;
        sb.push_back(r);
        n = 2;
      end
      6'h3F: begin
        sb.push_back(r);
        for (int i = 0; i < halt_cycles; i++) begin
          r = base(3'd6, m_cnt);
          r.halted = 1'b1;
          sb.push_back(r);
        end
        n = 2 + halt_cycles;
      end
      6'h00, 6'h08, 6'h23, 6'h2B, 6'h04: begin
        sb.push_back(r);
        r = base(3'd2, m_cnt);
        if (op == 6'h00) r.alu_op = 2'd2;
        else if (op == 6'h04) begin r.alu_op = 2'd1; r.pc_write = eq; end
        else r.alu_src_b = 2'd2;
        sb.push_back(r);
        if (op == 6'h04) n = 3;
        else if (op == 6'h23 || op == 6'h2B) begin
          r = base(3'd3, m_cnt);
          r.mem_read  = (op == 6'h23);
          r.mem_write = (op == 6'h2B);
          sb.push_back(r);
          if (op == 6'h2B) n = 4;
          else begin
            r = base(3'd4, m_cnt); r.reg_write = 1'b1; sb.push_back(r);
            n = 5;
          end
        end else begin
`ifdef OVERFLOW_TRAP_EN
          if (ovf) begin
            m_trap = 1'b1;
            r = base(3'd5, m_cnt);
          end else begin
            r = base(3'd4, m_cnt); r.reg_write = 1'b1;
          end
`else
          r = base(3'd4, m_cnt); r.reg_write = 1'b1;
`endif
          sb.push_back(r);
          n = 4;
        end
      end
      default: begin
        sb.push_back(r);
        m_ill = 1'b1;
        n = 2;
      end
    endcase
  endtask

  task automatic run(input logic [5:0] op, input logic eq, input logic ovf, input int hc);
    int n;
    issue(op, eq, ovf, hc, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic is_known(input logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B, 6'h3F};
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] o;
    case ($urandom_range(0, 9))
      0:       o = 6'h00;
      1:       o = 6'h08;
      2:       o = 6'h23;
      3:       o = 6'h2B;
      4, 5:    o = 6'h04;
      6:       o = 6'h02;
      7:       o = 6'h00;
      8:       o = 6'h08;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (is_known(o)) o = 6'($urandom_range(0, 63));
      end
    endcase
    return o;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    obs_t e;
    int   n;
    bus.opcode = 6'h00; bus.equal = 1'b0; bus.overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", sample(), '0);
    rst_n = 1'b1;

    // directed cases
    run(6'h00, 1'b0, 1'b0, 0);
    run(6'h23, 1'b0, 1'b0, 0);
    run(6'h2B, 1'b1, 1'b0, 0);
    run(6'h04, 1'b1, 1'b0, 0);
    run(6'h04, 1'b0, 1'b0, 0);
    run(6'h02, 1'b0, 1'b0, 0);
    run(6'h08, 1'b0, 1'b1, 0);
    run(6'h00, 1'b0, 1'b1, 0);
    run(6'h11, 1'b0, 1'b0, 0);
    for (int i = 0; i < 64; i++) run(6'h02, 1'b0, 1'b0, 0);

    // abort an R instruction in EXEC with reset
    issue(6'h00, 1'b0, 1'b0, 0, n);
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    check("exec_before_reset", sample(), e);
    rst_n = 1'b0;
    #1 check("reset_mid_exec", sample(), '0);
    sb.delete();
    m_cnt = '0; m_ill = 1'b0; m_trap = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_held", sample(), '0);
    rst_n = 1'b1;
    run(6'h00, 1'b0, 1'b0, 0);

    for (int i = 0; i < 150; i++)
      run(rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    run(6'h3F, 1'b0, 1'b0, 11);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
